act_rr_sched: RTL and testbench
===============================

# act_rr_sched

Round-robin scheduler that shares one leaky-ReLU activation lane among NUM_REQ producer channels (e.g. parallel conv-output streams). It arbitrates valid/ready requests in bursts and drives the lane's in_data/in_valid. A tag delay line matched to the lane latency routes each activated result back to its originating channel as a one-hot strobe. It sits between the conv accumulators and the pooling/writeback stage.

## Interface
- NUM_REQ, 4, number of requester channels (2..8)
- DATA_W, 8, sample width (signed fixed point, same as activation lane)
- ACT_LAT, 1, activation lane latency in cycles, in_valid to out_valid (1..4)
- BURST, 4, max consecutive words granted to one channel per turn (1..16)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-channel sample valid
- req_data  in  NUM_REQ*DATA_W  channel i on bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-channel accept; one-hot or zero
- act_in_data  out  DATA_W  to lane in_data
- act_in_valid  out  1  to lane in_valid
- act_out_data  in  DATA_W  from lane out_data
- act_out_valid  in  1  from lane out_valid
- rsp_data  out  DATA_W  activated sample, registered
- rsp_valid  out  NUM_REQ  one-hot owner strobe, registered; no backpressure
- gnt_id  out  $clog2(NUM_REQ)  current grant owner
- busy  out  1  GRANT state or any tag in flight
- err  out  1  sticky tag/lane mismatch (see Configuration)

## Operation
- States: IDLE, GRANT. Registers: state, gnt_id, ptr (next priority index), beat_cnt, tag pipe of ACT_LAT entries {v, id}.
- IDLE: req_ready = 0, act_in_valid = 0. If any req_valid, select first asserted index searching ptr, ptr+1, … wrapping mod NUM_REQ; next cycle state = GRANT, gnt_id = selected, beat_cnt = 0. Else stay.
- GRANT: req_ready[gnt_id] = 1 (combinational from state), others 0. Transfer when req_valid[gnt_id]: act_in_valid = 1, act_in_data = req_data slice gnt_id (combinational passthrough), beat_cnt++.
- Leave GRANT to IDLE when (transfer and beat_cnt == BURST-1) or req_valid[gnt_id] == 0; on leaving, ptr = (gnt_id+1) mod NUM_REQ. Dropping valid ends the turn immediately (no transfer that cycle).
- Tag pipe shifts every cycle; stage 0 loads {act_in_valid, gnt_id}. Stage ACT_LAT-1 output aligns with act_out_valid.
- Response: when act_out_valid, rsp_data <= act_out_data, rsp_valid <= one-hot(tag id) next cycle; else rsp_valid <= 0, rsp_data holds.
- Data is not modified; no arithmetic beyond counters. beat_cnt width $clog2(BURST+1).

## Timing
- Reset (async assert, sync-release use): state IDLE, gnt_id 0, ptr 0, beat_cnt 0, tag pipe cleared, rsp_data 0, rsp_valid 0, err 0. Combinational outputs then read req_ready 0, act_in_valid 0, busy 0.
- Arbitration costs one IDLE cycle per turn: steady two-channel throughput BURST/(BURST+1).
- End-to-end latency: req transfer cycle T -> lane out_valid at T+ACT_LAT -> rsp_valid at T+ACT_LAT+1.
- Single requester with continuous valid: BURST words, one IDLE bubble, re-granted (wrap search returns it).
- Reset mid-burst: in-flight tags lost; lane outputs arriving within ACT_LAT cycles after release are discarded (no rsp_valid), and err checking is masked for those ACT_LAT cycles.
- busy = (state == GRANT) or any tag v set.

## Configuration
- ACT_SCHED_ERR_EN defined: err sets (sticky until reset) when act_out_valid != tag v at the last stage, outside the post-reset mask; on mismatch with act_out_valid high the sample is dropped.
- Undefined: no check logic; err tied 0; act_out_valid alone drives rsp_valid using last-stage tag id.

## Test plan
- Reset: hold rst_n low with req_valid = 4'b1111 -> req_ready 0, act_in_valid 0, rsp_valid 0, busy 0.
- Single channel 2, 6 words 0x81..0x86, ACT_LAT=1, BURST=4 -> 4 words granted, 1 bubble, 2 more; rsp_valid = 4'b0100 two cycles after each transfer.
- All four channels continuous -> grant order 0,1,2,3,0 each for 4 words; ptr wrap from 3 to 0 verified.
- Channel 1 drops valid after 2 words -> immediate IDLE, next grant to channel 2 with ptr = 2.
- ACT_LAT=3, interleaved channels 0/3 -> every rsp_valid one-hot matches the issuing channel, data equals lane output.
- ACT_SCHED_ERR_EN: inject act_out_valid with empty tag -> err = 1 next cycle, stays until rst_n low.

Source files
------------

// File: rtl/act_rr_sched.sv
// Round-robin burst scheduler sharing one activation lane among NUM_REQ channels.
// A latency-matched tag pipe routes each lane result back as a one-hot strobe.
// Optional lane/tag consistency check: define ACT_SCHED_ERR_EN.
module act_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ACT_LAT = 1,
  parameter int BURST   = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(BURST + 1),
  localparam int MASK_W = $clog2(ACT_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         act_in_data,
  output logic                      act_in_valid,
  input  logic [DATA_W-1:0]         act_out_data,
  input  logic                      act_out_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [ID_W-1:0]           gnt_id,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]   w_sel;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic              w_any_req, w_own_valid;
  logic [ACT_LAT-1:0] r_tag_v;
  logic [ID_W-1:0]   r_tag_id [ACT_LAT];
  logic [MASK_W-1:0] r_mask_cnt;
  logic              w_mask, w_take;
  logic              w_tag_v_last;
  logic [ID_W-1:0]   w_tag_id_last;

  assign w_any_req     = |req_valid;
  assign w_own_valid   = req_valid[r_gnt_id];
  assign w_tag_v_last  = r_tag_v[ACT_LAT-1];
  assign w_tag_id_last = r_tag_id[ACT_LAT-1];
  assign w_mask        = (r_mask_cnt != '0);

  // Lowest rotated offset from ptr wins, so scan offsets high to low.
  always_comb begin
    w_sel = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) w_sel = ID_W'((int'(r_ptr) + k) % NUM_REQ);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt    = r_state;
    w_gnt_id_nxt   = r_gnt_id;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = S_GRANT;
          w_gnt_id_nxt   = w_sel;
          w_beat_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_own_valid) w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        if (!w_own_valid || (r_beat_cnt == CNT_W'(BURST - 1))) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = ID_W'((int'(r_gnt_id) + 1) % NUM_REQ);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    act_in_valid = 1'b0;
    if (r_state == S_GRANT) begin
      req_ready[r_gnt_id] = 1'b1;
      act_in_valid        = w_own_valid;
    end
  end

  assign act_in_data = req_data[int'(r_gnt_id)*DATA_W +: DATA_W];
  assign gnt_id      = r_gnt_id;
  assign busy        = (r_state == S_GRANT) || (|r_tag_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt_id   <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Tag pipe: stage i holds the issue of i+1 cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this is a short shift register, not a RAM; its valid bits must reset,
      // and ids are cleared too so the default-build strobe is deterministic.
      r_tag_v <= '0;
      for (int i = 0; i < ACT_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= act_in_valid;
      r_tag_id[0] <= r_gnt_id;
      for (int i = 1; i < ACT_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  // Lane results within ACT_LAT cycles of reset release belong to lost tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mask_cnt <= MASK_W'(ACT_LAT);
    else if (w_mask) r_mask_cnt <= r_mask_cnt - MASK_W'(1);
  end

`ifdef ACT_SCHED_ERR_EN
  logic r_err, w_mismatch;
  assign w_mismatch = !w_mask && (act_out_valid != w_tag_v_last);
  assign w_take     = !w_mask && act_out_valid && w_tag_v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_mismatch) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign w_take = !w_mask && act_out_valid;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= w_take ? (NUM_REQ'(1) << w_tag_id_last) : '0;
      if (w_take) rsp_data <= act_out_data;
    end
  end

endmodule

// File: tb/tb_act_rr_sched.sv
// Self-checking bench for act_rr_sched: directed vector table, hand-written corner
// sequences, and randomized traffic against a turn-level reference model.
module tb_act_rr_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int B  = 4;
  localparam int L3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic            inj;
  logic [N-1:0]    rdy1, rdy3, rsp_v1, rsp_v3;
  logic [DW-1:0]   ind1, ind3, lod1, lod3, rsp_d1, rsp_d3;
  logic            inv1, inv3, lov1, lov3, busy1, busy3, err1, err3;
  logic [1:0]      gnt1, gnt3;

  act_rr_sched #(.NUM_REQ(N), .DATA_W(DW), .ACT_LAT(1), .BURST(B)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .act_in_data(ind1), .act_in_valid(inv1),
    .act_out_data(lod1), .act_out_valid(lov1), .rsp_data(rsp_d1), .rsp_valid(rsp_v1),
    .gnt_id(gnt1), .busy(busy1), .err(err1));

  act_rr_sched #(.NUM_REQ(N), .DATA_W(DW), .ACT_LAT(L3), .BURST(B)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy3), .act_in_data(ind3), .act_in_valid(inv3),
    .act_out_data(lod3), .act_out_valid(lov3), .rsp_data(rsp_d3), .rsp_valid(rsp_v3),
    .gnt_id(gnt3), .busy(busy3), .err(err3));

  // Leaky-ReLU lane: negative inputs scaled by 1/4.
  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    logic signed [DW-1:0] s;
    s = x;
    s = s >>> 2;
    return x[DW-1] ? s : x;
  endfunction

  logic          l1_v;
  logic [DW-1:0] l1_d;
  logic          l3_v [L3];
  logic [DW-1:0] l3_d [L3];

  always @(posedge clk) begin
    l1_v    <= inv1;
    l1_d    <= relu(ind1);
    l3_v[0] <= inv3;
    l3_d[0] <= relu(ind3);
    for (int i = 1; i < L3; i++) begin
      l3_v[i] <= l3_v[i-1];
      l3_d[i] <= l3_d[i-1];
    end
  end

  assign lov1 = l1_v | inj;
  assign lod1 = inj ? 8'h55 : l1_d;
  assign lov3 = l3_v[L3-1];
  assign lod3 = l3_d[L3-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    inj       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] d2;
    logic [N-1:0]  e_rdy;
    logic          e_inv;
    logic [DW-1:0] e_ind;
    logic [N-1:0]  e_rsp;
    logic [DW-1:0] e_rspd;
  } vec_t;

  vec_t tbl [11];

  // Reference model state for the random phase.
  int            m_own, m_cnt, m_ptr, last_x;
  logic [N-1:0]  e_v1 [int];
  logic [DW-1:0] e_d1 [int];
  logic [N-1:0]  e_v3 [int];
  logic [DW-1:0] e_d3 [int];

  initial begin
    req_valid = '0;
    req_data  = '0;
    inj       = 1'b0;

    // Reset state with all requests pending.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", rdy1, 0);
    check("rst_in_valid", inv1, 0);
    check("rst_rsp_valid", rsp_v1, 0);
    check("rst_busy", busy1, 0);
    check("rst_err", err1, 0);
    check("rst_gnt", gnt1, 0);

    // Single channel 2, six words, BURST=4, ACT_LAT=1.
    tbl[0]  = '{4'b0100, 8'h81, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00};
    tbl[1]  = '{4'b0100, 8'h81, 4'b0100, 1'b1, 8'h81, 4'b0000, 8'h00};
    tbl[2]  = '{4'b0100, 8'h82, 4'b0100, 1'b1, 8'h82, 4'b0000, 8'h00};
    tbl[3]  = '{4'b0100, 8'h83, 4'b0100, 1'b1, 8'h83, 4'b0100, relu(8'h81)};
    tbl[4]  = '{4'b0100, 8'h84, 4'b0100, 1'b1, 8'h84, 4'b0100, relu(8'h82)};
    tbl[5]  = '{4'b0100, 8'h85, 4'b0000, 1'b0, 8'h00, 4'b0100, relu(8'h83)};
    tbl[6]  = '{4'b0100, 8'h85, 4'b0100, 1'b1, 8'h85, 4'b0100, relu(8'h84)};
    tbl[7]  = '{4'b0100, 8'h86, 4'b0100, 1'b1, 8'h86, 4'b0000, 8'h00};
    tbl[8]  = '{4'b0000, 8'h00, 4'b0100, 1'b0, 8'h00, 4'b0100, relu(8'h85)};
    tbl[9]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 8'h00, 4'b0100, relu(8'h86)};
    tbl[10] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 8'h00, 4'b0000, 8'h00};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req_valid        = tbl[i].v;
      req_data         = '0;
      req_data[23:16]  = tbl[i].d2;
      @(negedge clk);
      check($sformatf("ch2_ready[%0d]", i), rdy1, tbl[i].e_rdy);
      check($sformatf("ch2_in_valid[%0d]", i), inv1, tbl[i].e_inv);
      if (tbl[i].e_inv) check($sformatf("ch2_in_data[%0d]", i), ind1, tbl[i].e_ind);
      check($sformatf("ch2_rsp_valid[%0d]", i), rsp_v1, tbl[i].e_rsp);
      if (tbl[i].e_rsp != '0) check($sformatf("ch2_rsp_data[%0d]", i), rsp_d1, tbl[i].e_rspd);
      step();
    end

    // All channels continuous: order 0,1,2,3,0, one bubble per turn.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check($sformatf("rr_bubble[%0d]", t), rdy1, 0);
      step();
      for (int w = 0; w < B; w++) begin
        @(negedge clk);
        check($sformatf("rr_ready[%0d.%0d]", t, w), rdy1, 1 << (t % N));
        check($sformatf("rr_gnt[%0d.%0d]", t, w), gnt1, t % N);
        step();
      end
    end

    // Channel 1 drops after two words; pointer must move to 2, not back to 0.
    do_reset();
    req_valid = 4'b0110;
    step();
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      check("drop_gnt", gnt1, 1);
      check("drop_in_valid", inv1, 1);
      step();
    end
    req_valid = 4'b1101;
    @(negedge clk);
    check("drop_ready", rdy1, 4'b0010);
    check("drop_no_xfer", inv1, 0);
    step();
    @(negedge clk);
    check("drop_idle", rdy1, 0);
    step();
    @(negedge clk);
    check("drop_next_gnt", gnt1, 2);
    check("drop_next_ready", rdy1, 4'b0100);

    // Reset mid-burst, post-release mask, then orphan lane output.
    do_reset();
    req_valid = 4'b1111;
    repeat (3) step();
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("midrst_ready", rdy1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_rsp", rsp_v1, 0);
    step();
    step();
    rst_n = 1'b1;
    inj   = 1'b1;
    step();
    inj = 1'b0;
    @(negedge clk);
    check("mask_rsp", rsp_v1, 0);
    check("mask_err", err1, 0);
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    @(negedge clk);
`ifdef ACT_SCHED_ERR_EN
    check("orphan_err", err1, 1);
    check("orphan_dropped", rsp_v1, 0);
    step();
    step();
    @(negedge clk);
    check("err_sticky", err1, 1);
`else
    check("orphan_rsp", rsp_v1, 4'b0001);
    check("orphan_data", rsp_d1, 8'h55);
    check("orphan_err", err1, 0);
`endif
    rst_n = 1'b0;
    #1;
    check("err_clear", err1, 0);

    // Randomized traffic; second half uses only channels 0 and 3.
    do_reset();
    m_own  = -1;
    m_cnt  = 0;
    m_ptr  = 0;
    last_x = -100;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [N-1:0]  v;
      logic [N-1:0]  x_rdy;
      logic          x_inv;
      logic [DW-1:0] x_dat;
      int            nxt;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 8);
      if (cyc >= 400) v = v & 4'b1001;
      req_valid = v;
      req_data  = $urandom;
      @(negedge clk);

      x_rdy = '0;
      x_inv = 1'b0;
      x_dat = '0;
      check("rnd_busy1", busy1, (m_own >= 0) || (cyc - last_x >= 1 && cyc - last_x <= 1));
      check("rnd_busy3", busy3, (m_own >= 0) || (cyc - last_x >= 1 && cyc - last_x <= L3));
      nxt = m_own;
      if (m_own < 0) begin
        for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
        m_cnt = 0;
      end else begin
        x_rdy = 1 << m_own;
        check("rnd_gnt", gnt1, m_own);
        if (v[m_own]) begin
          x_inv  = 1'b1;
          x_dat  = req_data[m_own*DW +: DW];
          e_v1[cyc + 2]      = 1 << m_own;
          e_d1[cyc + 2]      = relu(x_dat);
          e_v3[cyc + L3 + 1] = 1 << m_own;
          e_d3[cyc + L3 + 1] = relu(x_dat);
          last_x = cyc;
          m_cnt++;
        end
        if (!v[m_own] || m_cnt == B) begin
          m_ptr = (m_own + 1) % N;
          nxt   = -1;
        end
      end
      m_own = nxt;

      check("rnd_ready1", rdy1, x_rdy);
      check("rnd_ready3", rdy3, x_rdy);
      check("rnd_in_valid", inv1, x_inv);
      if (x_inv) check("rnd_in_data", ind1, x_dat);
      if (e_v1.exists(cyc)) begin
        check("rnd_rsp1_v", rsp_v1, e_v1[cyc]);
        check("rnd_rsp1_d", rsp_d1, e_d1[cyc]);
      end else begin
        check("rnd_rsp1_v", rsp_v1, 0);
      end
      if (e_v3.exists(cyc)) begin
        check("rnd_rsp3_v", rsp_v3, e_v3[cyc]);
        check("rnd_rsp3_d", rsp_d3, e_d3[cyc]);
      end else begin
        check("rnd_rsp3_v", rsp_v3, 0);
      end
      check("rnd_err1", err1, 0);
      check("rnd_err3", err3, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
